// File: rtl/sync_handshake_pkg.sv
// sync_handshake_pkg: shared state encodings for the toggle req/ack CDC bridge.
// Imported by sync_handshake.
package sync_handshake_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } src_state_e;

    typedef enum logic {
        D_IDLE  = 1'b0,
        D_VALID = 1'b1
    } dst_state_e;

endpackage

// File: rtl/sync_ff.sv
// sync_ff: SYNC_WIDTH-deep single-bit synchronizer chain.
// Output is the last flop of the chain.
module sync_ff #(
    parameter int unsigned SYNC_WIDTH = 2,
    parameter logic        RESET_VAL  = 1'b0
) (
    input  logic clk,
    input  logic rst_ni,
    input  logic d,
    output logic q
);

    logic [SYNC_WIDTH-1:0] sync_q;

    // shift the asynchronous input through the flop chain
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {SYNC_WIDTH{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_WIDTH-2:0], d};
        end
    end

    assign q = sync_q[SYNC_WIDTH-1];

endmodule

// File: rtl/sync_handshake.sv
// sync_handshake: two-phase req/ack bridge moving one word clk_src -> clk_dst.
// Define SYNC_HS_XFER_CNT_EN to add the dst_xfer_cnt_o transfer counter.
module sync_handshake
    import sync_handshake_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 16,
    parameter int unsigned           SYNC_WIDTH = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
`ifdef SYNC_HS_XFER_CNT_EN
    ,
    parameter int unsigned           CNT_WIDTH  = 8
`endif
) (
    input  logic                  clk_src,
    input  logic                  rst_ni,
    input  logic                  clk_dst,
    input  logic                  src_valid_i,
    input  logic [DATA_WIDTH-1:0] src_data_i,
    output logic                  src_ready_o,
    output logic                  dst_valid_o,
    output logic [DATA_WIDTH-1:0] dst_data_o,
    input  logic                  dst_ready_i
`ifdef SYNC_HS_XFER_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  dst_xfer_cnt_o
`endif
);

    src_state_e            src_state_q;
    dst_state_e            dst_state_q;
    logic [DATA_WIDTH-1:0] hold_q;
    logic                  req_q;
    logic                  ack_q;
    logic                  seen_q;
    logic                  req_sync;
    logic                  ack_sync;

    // req toggle into the destination domain
    sync_ff #(
        .SYNC_WIDTH (SYNC_WIDTH),
        .RESET_VAL  (1'b0)
    ) u_req_sync (
        .clk    (clk_dst),
        .rst_ni (rst_ni),
        .d      (req_q),
        .q      (req_sync)
    );

    // ack toggle back into the source domain
    sync_ff #(
        .SYNC_WIDTH (SYNC_WIDTH),
        .RESET_VAL  (1'b0)
    ) u_ack_sync (
        .clk    (clk_src),
        .rst_ni (rst_ni),
        .d      (ack_q),
        .q      (ack_sync)
    );

    // source FSM: capture a word, toggle req, wait for matching ack
    always_ff @(posedge clk_src or negedge rst_ni) begin
        if (!rst_ni) begin
            src_state_q <= S_IDLE;
            src_ready_o <= 1'b1;
            req_q       <= 1'b0;
            hold_q      <= RESET_VAL;
        end else begin
            case (src_state_q)
                S_IDLE: begin
                    if (src_valid_i && src_ready_o) begin
                        hold_q      <= src_data_i;
                        req_q       <= ~req_q;
                        src_ready_o <= 1'b0;
                        src_state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (ack_sync == req_q) begin
                        src_ready_o <= 1'b1;
                        src_state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // destination FSM: present a new word on req edge, ack it on handshake
    always_ff @(posedge clk_dst or negedge rst_ni) begin
        if (!rst_ni) begin
            dst_state_q    <= D_IDLE;
            dst_valid_o    <= 1'b0;
            dst_data_o     <= RESET_VAL;
            seen_q         <= 1'b0;
            ack_q          <= 1'b0;
`ifdef SYNC_HS_XFER_CNT_EN
            dst_xfer_cnt_o <= '0;
`endif
        end else begin
            case (dst_state_q)
                D_IDLE: begin
                    if (req_sync != seen_q) begin
                        dst_data_o  <= hold_q;
                        seen_q      <= req_sync;
                        dst_valid_o <= 1'b1;
                        dst_state_q <= D_VALID;
                    end
                end
                D_VALID: begin
                    if (dst_valid_o && dst_ready_i) begin
                        dst_valid_o    <= 1'b0;
                        ack_q          <= seen_q;
                        dst_state_q    <= D_IDLE;
`ifdef SYNC_HS_XFER_CNT_EN
                        dst_xfer_cnt_o <= dst_xfer_cnt_o + 1'b1;
`endif
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sync_handshake.sv
// tb_sync_handshake: directed self-checking bench for sync_handshake.
// Define SYNC_HS_XFER_CNT_EN to also exercise the transfer counter.
module tb_sync_handshake;

    localparam int  DW       = 16;
    localparam int  SW       = 2;
    localparam int  N_STREAM = 1000;
    localparam time SRC_HALF = 43;
    localparam time DST_HALF = 5;

    logic          clk_src = 1'b0;
    logic          clk_dst = 1'b0;
    logic          rst_ni = 1'b0;
    logic          src_valid_i = 1'b0;
    logic [DW-1:0] src_data_i = '0;
    logic          src_ready_o;
    logic          dst_valid_o;
    logic [DW-1:0] dst_data_o;
    logic          dst_ready_i = 1'b0;
`ifdef SYNC_HS_XFER_CNT_EN
    logic [7:0]    dst_xfer_cnt_o;
`endif

    int            checks = 0;
    int            errors = 0;
    int            vld_cycles = 0;
    logic [DW-1:0] rx_q[$];
    logic [DW-1:0] exp_q[$];

    always #SRC_HALF clk_src = ~clk_src;
    always #DST_HALF clk_dst = ~clk_dst;

    sync_handshake #(
        .DATA_WIDTH (DW),
        .SYNC_WIDTH (SW),
        .RESET_VAL  (16'h0000)
`ifdef SYNC_HS_XFER_CNT_EN
        ,
        .CNT_WIDTH  (8)
`endif
    ) dut (
        .clk_src     (clk_src),
        .rst_ni      (rst_ni),
        .clk_dst     (clk_dst),
        .src_valid_i (src_valid_i),
        .src_data_i  (src_data_i),
        .src_ready_o (src_ready_o),
        .dst_valid_o (dst_valid_o),
        .dst_data_o  (dst_data_o),
        .dst_ready_i (dst_ready_i)
`ifdef SYNC_HS_XFER_CNT_EN
        ,
        .dst_xfer_cnt_o (dst_xfer_cnt_o)
`endif
    );

    // destination-side monitor, sampled mid-cycle
    always @(negedge clk_dst) begin
        if (dst_valid_o) vld_cycles++;
        if (dst_valid_o && dst_ready_i) rx_q.push_back(dst_data_o);
    end

    task automatic send(input logic [DW-1:0] w);
        int n;
        n = 0;
        src_data_i  = w;
        src_valid_i = 1'b1;
        @(negedge clk_src);
        while (!src_ready_o && n < 20) begin
            @(negedge clk_src);
            n++;
        end
        checks++;
        if (src_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL send_ready got=%0b want=1", src_ready_o);
        end
        @(posedge clk_src);
        #1;
        exp_q.push_back(w);
    endtask

    task automatic wait_rx(input int target);
        int n;
        n = 0;
        while (rx_q.size() < target && n < 400) begin
            @(posedge clk_dst);
            #1;
            n++;
        end
    endtask

    task automatic wait_src_ready();
        int n;
        n = 0;
        while (!src_ready_o && n < 20) begin
            @(posedge clk_src);
            #1;
            n++;
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_src);
        #1;
        checks++;
        if (src_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_src_ready got=%0b want=1", src_ready_o);
        end
        checks++;
        if (dst_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_dst_valid got=%0b want=0", dst_valid_o);
        end
        checks++;
        if (dst_data_o !== 16'h0000) begin
            errors++;
            $display("FAIL rst_dst_data got=%h want=0000", dst_data_o);
        end
`ifdef SYNC_HS_XFER_CNT_EN
        checks++;
        if (dst_xfer_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL rst_cnt got=%0d want=0", dst_xfer_cnt_o);
        end
`endif
        @(negedge clk_src);
        rst_ni = 1'b1;
        repeat (3) @(posedge clk_src);
        #1;
        checks++;
        if (src_ready_o !== 1'b1 || dst_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL post_rst_idle got=%0b%0b want=10",
                     src_ready_o, dst_valid_o);
        end
    endtask

    task automatic test_single();
        int n;
        int m;
        int v0;
        @(posedge clk_dst);
        #1;
        dst_ready_i = 1'b1;
        rx_q.delete();
        exp_q.delete();
        v0 = vld_cycles;
        send(16'hA5C3);
        src_valid_i = 1'b0;
        checks++;
        if (src_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL single_busy got=%0b want=0", src_ready_o);
        end
        n = 0;
        while (!dst_valid_o && n < 10) begin
            @(posedge clk_dst);
            #1;
            n++;
        end
        checks++;
        if (dst_valid_o !== 1'b1 || n > SW + 2) begin
            errors++;
            $display("FAIL single_latency got=%0d want<=%0d", n, SW + 2);
        end
        checks++;
        if (dst_data_o !== 16'hA5C3) begin
            errors++;
            $display("FAIL single_data got=%h want=a5c3", dst_data_o);
        end
        @(posedge clk_dst);
        #1;
        checks++;
        if (dst_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_drop got=%0b want=0", dst_valid_o);
        end
        m = 0;
        while (!src_ready_o && m < 10) begin
            @(posedge clk_src);
            #1;
            m++;
        end
        checks++;
        if (src_ready_o !== 1'b1 || m > SW + 2) begin
            errors++;
            $display("FAIL single_ack_lat got=%0d want<=%0d", m, SW + 2);
        end
        checks++;
        if (rx_q.size() !== 1 || vld_cycles - v0 !== 1) begin
            errors++;
            $display("FAIL single_pulse got=%0d/%0d want=1/1",
                     rx_q.size(), vld_cycles - v0);
        end
    endtask

    task automatic test_stream();
        rx_q.delete();
        exp_q.delete();
        for (int i = 0; i < N_STREAM; i++) begin
            send(DW'($urandom));
        end
        src_valid_i = 1'b0;
        wait_rx(N_STREAM);
        repeat (20) @(posedge clk_dst);
        #1;
        checks++;
        if (rx_q.size() !== N_STREAM) begin
            errors++;
            $display("FAIL stream_count got=%0d want=%0d",
                     rx_q.size(), N_STREAM);
        end
        for (int i = 0; i < N_STREAM && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL stream_word[%0d] got=%h want=%h",
                         i, rx_q[i], exp_q[i]);
            end
        end
        wait_src_ready();
    endtask

    task automatic test_hold();
        int  n;
        bit  held;
        @(posedge clk_dst);
        #1;
        dst_ready_i = 1'b0;
        rx_q.delete();
        exp_q.delete();
        send(16'h5A5A);
        src_valid_i = 1'b0;
        n = 0;
        while (!dst_valid_o && n < 10) begin
            @(posedge clk_dst);
            #1;
            n++;
        end
        checks++;
        if (dst_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL hold_valid got=%0b want=1", dst_valid_o);
        end
        held = 1'b1;
        repeat (50) begin
            @(posedge clk_dst);
            #1;
            if (dst_valid_o !== 1'b1 || dst_data_o !== 16'h5A5A ||
                src_ready_o !== 1'b0)
                held = 1'b0;
        end
        checks++;
        if (held !== 1'b1) begin
            errors++;
            $display("FAIL hold_stable got=%0b%h%0b want=15a5a0",
                     dst_valid_o, dst_data_o, src_ready_o);
        end
        dst_ready_i = 1'b1;
        @(posedge clk_dst);
        #1;
        checks++;
        if (dst_valid_o !== 1'b0 || rx_q.size() !== 1) begin
            errors++;
            $display("FAIL hold_release got=%0b/%0d want=0/1",
                     dst_valid_o, rx_q.size());
        end
        wait_src_ready();
        checks++;
        if (src_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL hold_src_ready got=%0b want=1", src_ready_o);
        end
    endtask

    task automatic test_reset_mid();
        int v0;
        rx_q.delete();
        exp_q.delete();
        send(16'hDEAD);
        src_valid_i = 1'b0;
        rst_ni = 1'b0;
        v0 = vld_cycles;
        #30;
        rst_ni = 1'b1;
        repeat (40) @(posedge clk_dst);
        #1;
        checks++;
        if (vld_cycles !== v0 || rx_q.size() !== 0) begin
            errors++;
            $display("FAIL mid_rst_spurious got=%0d want=0",
                     vld_cycles - v0);
        end
        checks++;
        if (src_ready_o !== 1'b1 || dst_data_o !== 16'h0000) begin
            errors++;
            $display("FAIL mid_rst_idle got=%0b/%h want=1/0000",
                     src_ready_o, dst_data_o);
        end
        send(16'h1234);
        src_valid_i = 1'b0;
        wait_rx(1);
        checks++;
        if (rx_q.size() !== 1 || rx_q[0] !== 16'h1234) begin
            errors++;
            $display("FAIL mid_rst_next got=%0d/%h want=1/1234",
                     rx_q.size(), dst_data_o);
        end
        wait_src_ready();
    endtask

`ifdef SYNC_HS_XFER_CNT_EN
    task automatic test_xfer_cnt();
        @(posedge clk_src);
        #1;
        rst_ni = 1'b0;
        @(negedge clk_src);
        rst_ni = 1'b1;
        rx_q.delete();
        exp_q.delete();
        @(posedge clk_src);
        #1;
        checks++;
        if (dst_xfer_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL cnt_start got=%0d want=0", dst_xfer_cnt_o);
        end
        for (int i = 1; i <= 300; i++) begin
            send(DW'(i));
            src_valid_i = 1'b0;
            if (i == 256) begin
                wait_rx(256);
                checks++;
                if (dst_xfer_cnt_o !== 8'd0) begin
                    errors++;
                    $display("FAIL cnt_wrap got=%0d want=0", dst_xfer_cnt_o);
                end
            end
        end
        wait_rx(300);
        checks++;
        if (dst_xfer_cnt_o !== 8'd44) begin
            errors++;
            $display("FAIL cnt_final got=%0d want=44", dst_xfer_cnt_o);
        end
        wait_src_ready();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_hold();
        test_reset_mid();
`ifdef SYNC_HS_XFER_CNT_EN
        test_xfer_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
